// File: rtl/mem_stage.sv
// Memory-access stage of the RV32 pipeline: registers execute results, runs data-bus loads/stores, aligns and extends load data.
// Latency: non-memory ops 1 cycle; loads/stores 1 issue cycle + W wait cycles + 1 result cycle (or ACK_TIMEOUT REQ cycles on timeout).
// Backpressure: mem_stall_o is high for every cycle in REQ; upstream holds while it is high; dack_i is ignored outside REQ.
module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rd_index_i,
    input  logic [31:0] ex_alu_res_i,
    input  logic [31:0] ex_mem_data_i,
    input  logic        ex_mem_rd_i,
    input  logic        ex_mem_wr_i,
    input  logic        ex_mem_signed_i,
    input  logic [1:0]  ex_mem_size_i,
    output logic        mem_stall_o,
    output logic [31:0] daddr_o,
    output logic [31:0] dwdata_o,
    output logic [3:0]  dbe_o,
    output logic [1:0]  dsize_o,
    output logic        drd_o,
    output logic        dwr_o,
    input  logic        dack_i,
    input  logic [31:0] drdata_i,
    output logic        mem_valid_o,
    output logic [4:0]  mem_rd_index_o,
    output logic [31:0] mem_wb_alu_result_o,
    output logic        mem_access_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_misalign_o,
    output logic        mem_buserr_o
);

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;

    // bus request registers, held stable for the whole REQ phase
    logic        req_rd_q, req_wr_q;
    logic [31:0] daddr_q, dwdata_q;
    logic [3:0]  dbe_q;
    logic [1:0]  dsize_q;
    logic [1:0]  ld_lane_q;
    logic        ld_signed_q;
    logic [1:0]  ld_size_q;
    logic [4:0]  pend_rd_q;
    logic [CW-1:0] wait_cnt_q;

    // result registers seen by write-back and forwarding
    logic        valid_q, misalign_q, buserr_q, access_q;
    logic [4:0]  rd_index_q;
    logic [31:0] alu_q, rdata_q;

    // decoded execute-stage request
    logic        ex_load, ex_store, ex_mem, ex_misalign;
    logic [1:0]  ex_size, ex_lane;
    logic [3:0]  ex_be;
    logic [31:0] ex_wdata;

    logic        timeout;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // decode execute-stage fields; read wins when both read and write are set
    always_comb begin
        ex_load     = ex_mem_rd_i;
        ex_store    = ex_mem_wr_i & ~ex_mem_rd_i;
        ex_mem      = ex_mem_rd_i | ex_mem_wr_i;
        ex_size     = (ex_mem_size_i == 2'b11) ? 2'b10 : ex_mem_size_i;
        ex_lane     = ex_alu_res_i[1:0];
        ex_misalign = 1'b0;
        ex_be       = 4'b1111;
        ex_wdata    = ex_mem_data_i;
        case (ex_size)
            2'b00: begin
                ex_be    = 4'b0001 << ex_lane;
                ex_wdata = {4{ex_mem_data_i[7:0]}};
            end
            2'b01: begin
                ex_misalign = ex_lane[0];
                ex_be       = ex_lane[1] ? 4'b1100 : 4'b0011;
                ex_wdata    = {2{ex_mem_data_i[15:0]}};
            end
            default: begin
                ex_misalign = (ex_lane != 2'b00);
            end
        endcase
        ex_misalign = ex_misalign & ex_mem;
    end

    // ack timeout fires on the last allowed REQ cycle when no acknowledge arrives
    always_comb begin
        timeout = 1'b0;
        if (ACK_TIMEOUT != 0) begin
            timeout = (state_q == REQ) && !dack_i && (wait_cnt_q == TO_LAST);
        end
    end

    // select the load lane from the bus and extend it
    always_comb begin
        ld_byte = drdata_i[7:0];
        case (ld_lane_q)
            2'b01:   ld_byte = drdata_i[15:8];
            2'b10:   ld_byte = drdata_i[23:16];
            2'b11:   ld_byte = drdata_i[31:24];
            default: ld_byte = drdata_i[7:0];
        endcase
        ld_half = ld_lane_q[1] ? drdata_i[31:16] : drdata_i[15:0];
        case (ld_size_q)
            2'b00:   ld_data = {{24{ld_signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{ld_signed_q & ld_half[15]}}, ld_half};
            default: ld_data = drdata_i;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ex_valid_i && ex_mem && !ex_misalign) state_d = REQ;
            REQ:  if (dack_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state-derived outputs; async reset drops the request strobes at once
    always_comb begin
        mem_stall_o = (state_q == REQ);
        drd_o       = (state_q == REQ) & req_rd_q;
        dwr_o       = (state_q == REQ) & req_wr_q;
    end

    // capture execute results, bus request and completion data
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            daddr_q     <= '0;
            dwdata_q    <= '0;
            dbe_q       <= '0;
            dsize_q     <= '0;
            ld_lane_q   <= '0;
            ld_signed_q <= 1'b0;
            ld_size_q   <= '0;
            pend_rd_q   <= '0;
            wait_cnt_q  <= '0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            buserr_q    <= 1'b0;
            access_q    <= 1'b0;
            rd_index_q  <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
        end else begin
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ex_valid_i) begin
                        rd_index_q <= '0;
                        access_q   <= 1'b0;
                    end else if (!ex_mem || ex_misalign) begin
                        valid_q    <= 1'b1;
                        misalign_q <= ex_misalign;
                        rd_index_q <= ex_mem ? 5'd0 : ex_rd_index_i;
                        alu_q      <= ex_alu_res_i;
                        access_q   <= 1'b0;
                    end else begin
                        req_rd_q    <= ex_load;
                        req_wr_q    <= ex_store;
                        daddr_q     <= {ex_alu_res_i[31:2], 2'b00};
                        dwdata_q    <= ex_wdata;
                        dbe_q       <= ex_be;
                        dsize_q     <= ex_size;
                        ld_lane_q   <= ex_lane;
                        ld_signed_q <= ex_mem_signed_i;
                        ld_size_q   <= ex_size;
                        pend_rd_q   <= ex_load ? ex_rd_index_i : 5'd0;
                        wait_cnt_q  <= '0;
                        alu_q       <= ex_alu_res_i;
                        rd_index_q  <= '0;
                        access_q    <= 1'b0;
                    end
                end
                REQ: begin
                    if (dack_i) begin
                        valid_q    <= 1'b1;
                        rd_index_q <= pend_rd_q;
                        access_q   <= req_rd_q;
                        if (req_rd_q) rdata_q <= ld_data;
                        req_rd_q   <= 1'b0;
                        req_wr_q   <= 1'b0;
                    end else if (timeout) begin
                        valid_q    <= 1'b1;
                        buserr_q   <= 1'b1;
                        rd_index_q <= '0;
                        access_q   <= 1'b0;
                        req_rd_q   <= 1'b0;
                        req_wr_q   <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign daddr_o             = daddr_q;
    assign dwdata_o            = dwdata_q;
    assign dbe_o               = dbe_q;
    assign dsize_o             = dsize_q;
    assign mem_valid_o         = valid_q;
    assign mem_rd_index_o      = rd_index_q;
    assign mem_wb_alu_result_o = alu_q;
    assign mem_access_o        = access_q;
    assign mem_rdata_o         = rdata_q;
    assign mem_misalign_o      = misalign_q;
    assign mem_buserr_o        = buserr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written pipeline/reset sequences, randomized transactions vs a reference model.
// Each transaction is issued, the bus is acknowledged after W wait cycles (or never), and the result pulse is checked.
// Bus stability, request strobe counts and stall length are checked alongside the write-back fields.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic        ex_valid;
    logic [4:0]  ex_rd_index;
    logic [31:0] ex_alu_res, ex_mem_data;
    logic        ex_mem_rd, ex_mem_wr, ex_mem_signed;
    logic [1:0]  ex_mem_size;
    logic        mem_stall;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;
    logic [1:0]  dsize;
    logic        drd, dwr, dack;
    logic [31:0] drdata;
    logic        mem_valid;
    logic [4:0]  mem_rd_index;
    logic [31:0] mem_wb_alu_result;
    logic        mem_access;
    logic [31:0] mem_rdata;
    logic        mem_misalign, mem_buserr;

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .ex_valid_i(ex_valid), .ex_rd_index_i(ex_rd_index), .ex_alu_res_i(ex_alu_res),
        .ex_mem_data_i(ex_mem_data), .ex_mem_rd_i(ex_mem_rd), .ex_mem_wr_i(ex_mem_wr),
        .ex_mem_signed_i(ex_mem_signed), .ex_mem_size_i(ex_mem_size),
        .mem_stall_o(mem_stall), .daddr_o(daddr), .dwdata_o(dwdata), .dbe_o(dbe),
        .dsize_o(dsize), .drd_o(drd), .dwr_o(dwr), .dack_i(dack), .drdata_i(drdata),
        .mem_valid_o(mem_valid), .mem_rd_index_o(mem_rd_index),
        .mem_wb_alu_result_o(mem_wb_alu_result), .mem_access_o(mem_access),
        .mem_rdata_o(mem_rdata), .mem_misalign_o(mem_misalign), .mem_buserr_o(mem_buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, sgn;
        logic [1:0]  size;
        logic [31:0] addr, data;
        logic [4:0]  ex_rd;
        logic [31:0] drdata;
        int          w;        // wait cycles before ack; large means never
        int          e_req;    // expected cycles in REQ (stall length)
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_daddr;
        logic [1:0]  e_dsize;
        logic [4:0]  e_rd;
        logic        e_acc, e_mis, e_berr;
        logic [31:0] e_rdata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_rdata;

    // observations of one transaction
    int          obs_req, obs_rdcyc, obs_wrcyc, obs_unstable;
    logic        obs_seen, obs_after;
    logic [31:0] obs_daddr, obs_wdata, obs_alu, obs_rdata;
    logic [3:0]  obs_be;
    logic [1:0]  obs_dsize;
    logic [4:0]  obs_rd;
    logic        obs_acc, obs_mis, obs_berr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: expected outcome from the architectural rules
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t   e = v;
        int     nb, a, bits;
        bit     is_mem, mis, tmo;
        longint val;
        is_mem = v.rd || v.wr;
        nb   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        a    = int'(v.addr % 4);
        mis  = is_mem && ((v.addr % nb) != 0);
        tmo  = is_mem && !mis && (v.w + 1 > TO);
        e.e_req   = (!is_mem || mis) ? 0 : (tmo ? TO : v.w + 1);
        e.e_daddr = v.addr - a;
        e.e_dsize = (nb == 4) ? 2'd2 : v.size;
        e.e_be    = 4'(((1 << nb) - 1) << a);
        for (int k = 0; k < 4; k++) e.e_wdata[8*k +: 8] = v.data[8*(k % nb) +: 8];
        bits = 8 * nb;
        val  = longint'(v.drdata >> (8 * a)) % (longint'(1) << bits);
        if (v.sgn && val >= (longint'(1) << (bits - 1))) val = val - (longint'(1) << bits);
        e.e_mis  = mis;
        e.e_berr = tmo;
        e.e_acc  = v.rd && !mis && !tmo;
        e.e_rd   = !is_mem ? v.ex_rd : (e.e_acc ? v.ex_rd : 5'd0);
        e.e_rdata = e.e_acc ? 32'(val) : prev;
        return e;
    endfunction

    // present one instruction, serve the bus, observe the result pulse
    task automatic do_txn(input vec_t v);
        logic done;
        ex_valid = 1'b1; ex_mem_rd = v.rd; ex_mem_wr = v.wr; ex_mem_signed = v.sgn;
        ex_mem_size = v.size; ex_alu_res = v.addr; ex_mem_data = v.data; ex_rd_index = v.ex_rd;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        obs_req = 0; obs_rdcyc = 0; obs_wrcyc = 0; obs_unstable = 0; obs_seen = 1'b0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (mem_valid) begin
                obs_seen = 1'b1; done = 1'b1;
                obs_rd = mem_rd_index; obs_alu = mem_wb_alu_result; obs_acc = mem_access;
                obs_rdata = mem_rdata; obs_mis = mem_misalign; obs_berr = mem_buserr;
            end else if (mem_stall) begin
                obs_req++;
                if (drd) obs_rdcyc++;
                if (dwr) obs_wrcyc++;
                if (obs_req == 1) begin
                    obs_daddr = daddr; obs_wdata = dwdata; obs_be = dbe; obs_dsize = dsize;
                end else if (daddr !== obs_daddr || dwdata !== obs_wdata || dbe !== obs_be || dsize !== obs_dsize) begin
                    obs_unstable++;
                end
                dack   = (obs_req == v.w + 1);
                drdata = dack ? v.drdata : $urandom;
            end
        end
        dack = 1'b0;
        @(negedge clk);
        obs_after = mem_valid;
    endtask

    task automatic check_txn(input string tag, input vec_t e);
        bit st;
        st = e.wr && !e.rd;
        chk({tag, " result_seen"}, 32'(obs_seen), 32'd1);
        chk({tag, " stall_cycles"}, obs_req, e.e_req);
        chk({tag, " drd_cycles"}, obs_rdcyc, e.rd ? e.e_req : 0);
        chk({tag, " dwr_cycles"}, obs_wrcyc, st ? e.e_req : 0);
        if (e.e_req > 0) begin
            chk({tag, " daddr"}, obs_daddr, e.e_daddr);
            chk({tag, " dbe"}, 32'(obs_be), 32'(e.e_be));
            chk({tag, " dsize"}, 32'(obs_dsize), 32'(e.e_dsize));
            chk({tag, " bus_unstable"}, obs_unstable, 0);
            if (st) chk({tag, " dwdata"}, obs_wdata, e.e_wdata);
        end
        chk({tag, " rd_index"}, 32'(obs_rd), 32'(e.e_rd));
        chk({tag, " alu_result"}, obs_alu, e.addr);
        chk({tag, " access"}, 32'(obs_acc), 32'(e.e_acc));
        chk({tag, " misalign"}, 32'(obs_mis), 32'(e.e_mis));
        chk({tag, " buserr"}, 32'(obs_berr), 32'(e.e_berr));
        chk({tag, " rdata"}, obs_rdata, e.e_rdata);
        chk({tag, " valid_pulse"}, 32'(obs_after), 32'd0);
    endtask

    vec_t tbl[13];

    initial begin
        vec_t v, e;
        //            rd    wr    sgn   size   addr        data          rd     drdata        w  req be     wdata          daddr       dsz    rdo    acc   mis   berr  rdata
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0,        5'd3,  32'hDEADBEEF, 2, 3, 4'hF, 32'h0,        32'h100, 2'd2, 5'd3,  1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h103, 32'h0,        5'd4,  32'h80123456, 0, 1, 4'h8, 32'h0,        32'h100, 2'd0, 5'd4,  1'b1, 1'b0, 1'b0, 32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h103, 32'h0,        5'd6,  32'h80123456, 1, 2, 4'h8, 32'h0,        32'h100, 2'd0, 5'd6,  1'b1, 1'b0, 1'b0, 32'h00000080};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h202, 32'h1234ABCD, 5'd7,  32'h0,        1, 2, 4'hC, 32'hABCDABCD, 32'h200, 2'd1, 5'd0,  1'b0, 1'b0, 1'b0, 32'h00000080};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h101, 32'h0,        5'd8,  32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   2'd0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h00000080};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h102, 32'h0,        5'd9,  32'h80017FFF, 0, 1, 4'hC, 32'h0,        32'h100, 2'd1, 5'd9,  1'b1, 1'b0, 1'b0, 32'hFFFF8001};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h104, 32'hFFFFFFFF, 5'd10, 32'h11223344, 3, 4, 4'hF, 32'h0,        32'h104, 2'd2, 5'd10, 1'b1, 1'b0, 1'b0, 32'h11223344};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h108, 32'h0,        5'd11, 32'h0,        9, 4, 4'hF, 32'h0,        32'h108, 2'd2, 5'd0,  1'b0, 1'b0, 1'b1, 32'h11223344};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h7,   32'h0,        5'd5,  32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   2'd0, 5'd5,  1'b0, 1'b0, 1'b0, 32'h11223344};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h101, 32'h0,        5'd12, 32'hA5B6C7D8, 0, 1, 4'h2, 32'h0,        32'h100, 2'd0, 5'd12, 1'b1, 1'b0, 1'b0, 32'h000000C7};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h203, 32'h55,       5'd13, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   2'd0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h000000C7};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd3, 32'h300, 32'hCAFEF00D, 5'd14, 32'h0,        0, 1, 4'hF, 32'hCAFEF00D, 32'h300, 2'd2, 5'd0,  1'b0, 1'b0, 1'b0, 32'h000000C7};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h502, 32'h123456EE, 5'd1,  32'h0,        0, 1, 4'h4, 32'hEEEEEEEE, 32'h500, 2'd0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h000000C7};

        rst_n = 1'b0; ex_valid = 1'b0; ex_rd_index = '0; ex_alu_res = '0; ex_mem_data = '0;
        ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_mem_signed = 1'b0; ex_mem_size = '0;
        dack = 1'b0; drdata = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst stall", 32'(mem_stall), 0);
        chk("rst drd", 32'(drd), 0);
        chk("rst dwr", 32'(dwr), 0);
        chk("rst daddr", daddr, 0);
        chk("rst dwdata", dwdata, 0);
        chk("rst dbe", 32'(dbe), 0);
        chk("rst dsize", 32'(dsize), 0);
        chk("rst valid", 32'(mem_valid), 0);
        chk("rst rd_index", 32'(mem_rd_index), 0);
        chk("rst alu", mem_wb_alu_result, 0);
        chk("rst access", 32'(mem_access), 0);
        chk("rst rdata", mem_rdata, 0);
        chk("rst misalign", 32'(mem_misalign), 0);
        chk("rst buserr", 32'(mem_buserr), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle stall", 32'(mem_stall), 0);

        // directed table
        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i]);
            check_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // ADD followed back-to-back by a zero-wait load
        ex_valid = 1'b1; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_rd_index = 5'd5; ex_alu_res = 32'd7;
        @(posedge clk); #1;
        ex_mem_rd = 1'b1; ex_mem_size = 2'd2; ex_mem_signed = 1'b0; ex_alu_res = 32'h100; ex_rd_index = 5'd6;
        @(negedge clk);
        chk("add valid", 32'(mem_valid), 1);
        chk("add rd", 32'(mem_rd_index), 5);
        chk("add result", mem_wb_alu_result, 7);
        chk("add no_stall", 32'(mem_stall), 0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("b2b load issued", 32'(drd), 1);
        chk("b2b load stall", 32'(mem_stall), 1);
        chk("b2b load daddr", daddr, 32'h100);
        dack = 1'b1; drdata = 32'h0BADF00D;
        @(posedge clk); #1;
        dack = 1'b0;
        @(negedge clk);
        chk("b2b load valid", 32'(mem_valid), 1);
        chk("b2b load stall_end", 32'(mem_stall), 0);
        chk("b2b load rdata", mem_rdata, 32'h0BADF00D);
        chk("b2b load access", 32'(mem_access), 1);
        chk("b2b load rd", 32'(mem_rd_index), 6);

        // asynchronous reset in the middle of an access
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_res = 32'h400; ex_rd_index = 5'd2;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("midrst drd_before", 32'(drd), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst drd", 32'(drd), 0);
        chk("midrst stall", 32'(mem_stall), 0);
        chk("midrst daddr", daddr, 0);
        chk("midrst rdata", mem_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst stall", 32'(mem_stall), 0);
        chk("postrst drd", 32'(drd), 0);
        model_rdata = 32'h0;

        // randomized transactions against the reference model
        for (int i = 0; i < 200; i++) begin
            int kind;
            kind    = int'($urandom_range(0, 3));
            v.rd    = (kind == 1) || (kind == 3);
            v.wr    = (kind == 2) || (kind == 3);
            v.sgn   = 1'($urandom);
            v.size  = 2'($urandom);
            v.addr  = $urandom;
            v.data  = $urandom;
            v.ex_rd = 5'($urandom);
            v.drdata = $urandom;
            v.w     = int'($urandom_range(0, 5));
            e = model(v, model_rdata);
            do_txn(v);
            check_txn($sformatf("rnd%0d", i), e);
            model_rdata = e.e_rdata;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
